// File: rtl/mult_pkg.sv
// Shared definitions for the sequential Booth multiplier: FSM states,
// Booth step operation codes and operand mode encoding.
// No logic; types and constants only.
package mult_pkg;

   // Multiplier control FSM states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } mult_state_t;

   // Booth recoding of the inspected multiplier bit pair P[1:0]
   localparam logic [1:0] BOOTH_NOP = 2'b00;
   localparam logic [1:0] BOOTH_ADD = 2'b01;
   localparam logic [1:0] BOOTH_SUB = 2'b10;

   // Operand interpretation selected per operation
   localparam logic MODE_UNSIGNED = 1'b0;
   localparam logic MODE_SIGNED   = 1'b1;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: recode P[1:0], add/sub M on the upper field, arithmetic shift.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register the result.
module booth_step
   import mult_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH+2:0] p,
   input  logic [WIDTH:0]     m,
   output logic [2*WIDTH+2:0] p_next
);

   logic [1:0]     op;
   logic [WIDTH:0] upper;
   logic [WIDTH:0] sum;

   // Recode the current multiplier bit and the previously shifted-out bit
   always_comb begin
      op = BOOTH_NOP;
      case (p[1:0])
         2'b01:   op = BOOTH_ADD;
         2'b10:   op = BOOTH_SUB;
         default: op = BOOTH_NOP;
      endcase
   end

   // Modulo W+1 add/sub on the upper field, then shift right replicating the new MSB
   always_comb begin
      upper = p[2*WIDTH+2:WIDTH+2];
      sum   = upper;
      case (op)
         BOOTH_ADD: sum = upper + m;
         BOOTH_SUB: sum = upper - m;
         default:   sum = upper;
      endcase
      p_next = {sum[WIDTH], sum, p[WIDTH+1:1]};
   end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned per operation, full 2W-bit product.
// Latency: W+2 cycles from accepted start to done; one product per W+2 cycles.
// Backpressure: start only sampled while idle (busy=0); requests while busy are dropped.
module booth_mult_seq
   import mult_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int             CW       = $clog2(WIDTH + 2);
   localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH);

   mult_state_t         state;
   logic [2*WIDTH+2:0]  p;
   logic [2*WIDTH+2:0]  p_next;
   logic [WIDTH:0]      m;
   logic [CW-1:0]       cnt;
   logic [WIDTH:0]      a_ext;
   logic [WIDTH:0]      b_ext;
   logic                ext_sign;

   // Widen operands by one bit so unsigned values stay positive under signed Booth recoding
   always_comb begin
      ext_sign = (signed_mode == MODE_SIGNED);
      a_ext    = {ext_sign & a[WIDTH-1], a};
      b_ext    = {ext_sign & b[WIDTH-1], b};
   end

   booth_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .p      (p),
      .m      (m),
      .p_next (p_next)
   );

   // Control FSM with datapath registers; busy/done/hi/lo are registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
         p     <= '0;
         m     <= '0;
         cnt   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  m     <= a_ext;
                  p     <= {{(WIDTH+1){1'b0}}, b_ext, 1'b0};
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               p   <= p_next;
               cnt <= cnt + 1'b1;
               // W+1 steps cover every bit of the widened multiplier
               if (cnt == CNT_LAST) begin
                  state <= FINISH;
               end
            end
            FINISH: begin
               lo    <= p[WIDTH:1];
               hi    <= p[2*WIDTH:WIDTH+1];
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq at WIDTH=32 and WIDTH=8.
// Expected products come from plain wide multiplication of the extended operands.
// Handshake timing, latency, pulse width and reset abort are checked alongside.
module tb_booth_mult_seq;

   typedef struct {
      logic [63:0] prod;
      int          acc;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset;

   logic        start32, sm32, busy32, done32;
   logic [31:0] a32, b32, hi32, lo32;
   logic        start8, sm8, busy8, done8;
   logic [7:0]  a8, b8, hi8, lo8;

   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;
   int   ndone32 = 0, ndone8 = 0;
   int   nissued32 = 0, nissued8 = 0;
   logic done32_prev = 1'b0, done8_prev = 1'b0;

   exp_t sb32[$];
   exp_t sb8[$];

   booth_mult_seq #(.WIDTH(32)) dut32 (
      .clock       (clock),
      .reset       (reset),
      .start       (start32),
      .signed_mode (sm32),
      .a           (a32),
      .b           (b32),
      .busy        (busy32),
      .done        (done32),
      .hi          (hi32),
      .lo          (lo32)
   );

   booth_mult_seq #(.WIDTH(8)) dut8 (
      .clock       (clock),
      .reset       (reset),
      .start       (start8),
      .signed_mode (sm8),
      .a           (a8),
      .b           (b8),
      .busy        (busy8),
      .done        (done8),
      .hi          (hi8),
      .lo          (lo8)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [63:0] model32(input logic sm, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] xe, ye;
      xe = sm ? {{32{x[31]}}, x} : {32'b0, x};
      ye = sm ? {{32{y[31]}}, y} : {32'b0, y};
      return xe * ye;
   endfunction

   function automatic logic [15:0] model8(input logic sm, input logic [7:0] x, input logic [7:0] y);
      logic [15:0] xe, ye;
      xe = sm ? {{8{x[7]}}, x} : {8'b0, x};
      ye = sm ? {{8{y[7]}}, y} : {8'b0, y};
      return xe * ye;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Present a request when idle, push its expectation, hold start across the accepting edge
   task automatic issue32(input logic sm, input logic [31:0] x, input logic [31:0] y);
      exp_t e;
      int   n = 0;
      while (busy32 && n < 100) begin
         tick();
         n++;
      end
      if (busy32) chk("issue32_idle_timeout", busy32, 0);
      start32 = 1'b1;
      sm32    = sm;
      a32     = x;
      b32     = y;
      e.prod  = model32(sm, x, y);
      e.acc   = cyc + 1;
      sb32.push_back(e);
      nissued32++;
      tick();
      start32 = 1'b0;
      chk("busy32_after_accept", busy32, 1);
   endtask

   task automatic issue8(input logic sm, input logic [7:0] x, input logic [7:0] y);
      exp_t e;
      int   n = 0;
      while (busy8 && n < 100) begin
         tick();
         n++;
      end
      if (busy8) chk("issue8_idle_timeout", busy8, 0);
      start8 = 1'b1;
      sm8    = sm;
      a8     = x;
      b8     = y;
      e.prod = {48'b0, model8(sm, x, y)};
      e.acc  = cyc + 1;
      sb8.push_back(e);
      nissued8++;
      tick();
      start8 = 1'b0;
      chk("busy8_after_accept", busy8, 1);
   endtask

   task automatic wait_done32();
      int n = 0;
      while (!done32 && n < 100) begin
         tick();
         n++;
      end
      chk("wait_done32", done32, 1);
   endtask

   task automatic wait_done8();
      int n = 0;
      while (!done8 && n < 50) begin
         tick();
         n++;
      end
      chk("wait_done8", done8, 1);
   endtask

   // Result monitor, WIDTH=32: pop expectation on every done pulse
   always @(posedge clock) begin
      #1;
      if (done32) begin
         ndone32++;
         chk("done32_single_cycle", done32_prev, 0);
         if (sb32.size() == 0) begin
            chk("done32_unexpected", sb32.size(), 1);
         end else begin
            exp_t e;
            e = sb32.pop_front();
            chk("hi32", hi32, e.prod[63:32]);
            chk("lo32", lo32, e.prod[31:0]);
            chk("latency32", cyc - e.acc, 34);
            chk("busy32_at_done", busy32, 0);
         end
      end
      done32_prev = done32;
   end

   // Result monitor, WIDTH=8
   always @(posedge clock) begin
      #1;
      if (done8) begin
         ndone8++;
         chk("done8_single_cycle", done8_prev, 0);
         if (sb8.size() == 0) begin
            chk("done8_unexpected", sb8.size(), 1);
         end else begin
            exp_t e;
            e = sb8.pop_front();
            chk("hi8", hi8, e.prod[15:8]);
            chk("lo8", lo8, e.prod[7:0]);
            chk("latency8", cyc - e.acc, 10);
         end
      end
      done8_prev = done8;
   end

   initial begin
      reset   = 1'b1;
      start32 = 1'b0; sm32 = 1'b0; a32 = '0; b32 = '0;
      start8  = 1'b0; sm8  = 1'b0; a8  = '0; b8  = '0;
      repeat (3) tick();
      chk("rst_busy32", busy32, 0);
      chk("rst_done32", done32, 0);
      chk("rst_hi32", hi32, 0);
      chk("rst_lo32", lo32, 0);
      chk("rst_busy8", busy8, 0);
      chk("rst_hilo8", {hi8, lo8}, 0);
      reset = 1'b0;
      tick();

      // Directed 32-bit cases, including back-to-back starts during the done cycle
      issue32(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done32();
      issue32(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done32();
      issue32(1'b1, 32'h8000_0000, 32'h8000_0000);
      wait_done32();
      issue32(1'b1, 32'hFFFF_FFFD, 32'd5);
      wait_done32();
      issue32(1'b0, 32'd7, 32'd6);
      wait_done32();

      // Start pulsed mid-RUN with other operands must be ignored
      issue32(1'b0, 32'h0000_1234, 32'h0000_5678);
      repeat (5) tick();
      start32 = 1'b1; sm32 = 1'b1; a32 = 32'hDEAD_0001; b32 = 32'h8000_0003;
      tick();
      start32 = 1'b0;
      wait_done32();
      repeat (40) tick();

      // A few random operands in both modes
      for (int i = 0; i < 6; i++) begin
         issue32(1'($urandom_range(0, 1)), $urandom, $urandom);
         wait_done32();
      end

      // 8-bit instance
      issue8(1'b0, 8'hFF, 8'h02);
      wait_done8();
      issue8(1'b1, 8'hFF, 8'h02);
      wait_done8();
      issue8(1'b1, 8'h80, 8'h80);
      wait_done8();
      for (int i = 0; i < 6; i++) begin
         issue8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
         wait_done8();
      end
      tick();

      // Reset at step 10 of an operation, with a non-zero prior result on hi/lo
      issue32(1'b0, 32'hDEAD_BEEF, 32'h1234_5678);
      wait_done32();
      tick();
      issue32(1'b1, 32'h0BAD_F00D, 32'hCAFE_0001);
      repeat (9) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sb32.delete();
      nissued32--;
      chk("abort_busy32", busy32, 0);
      chk("abort_done32", done32, 0);
      chk("abort_hi32", hi32, 0);
      chk("abort_lo32", lo32, 0);
      repeat (45) tick();
      issue32(1'b1, 32'hFFFF_FFFD, 32'd5);
      wait_done32();
      repeat (5) tick();

      chk("sb32_drained", sb32.size(), 0);
      chk("sb8_drained", sb8.size(), 0);
      chk("done32_count", ndone32, nissued32);
      chk("done8_count", ndone8, nissued8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      n_err++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1);
   end

endmodule

// File: doc/booth_mult_seq.md
# booth_mult_seq

Parametrised sequential radix-2 Booth multiplier with a start/busy/done handshake and a per-operation signed/unsigned mode. It computes the full 2·WIDTH-bit product of two WIDTH-bit operands and returns it split into `hi` and `lo`. It sits beside the ALU in the datapath, driven by the control FSM for the mult (signed) and multu (unsigned) instructions.

## Interface
- `WIDTH`, default 32: operand width (≥ 4); the product is 2·WIDTH bits.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request. Sampled only in IDLE.
- `signed_mode`  in  1  1 = two's-complement operands, 0 = unsigned. Latched with the operands.
- `a`  in  WIDTH  multiplicand. Latched on accept.
- `b`  in  WIDTH  multiplier. Latched on accept.
- `busy`  out  1  high while state ≠ IDLE.
- `done`  out  1  one-cycle pulse when `hi`/`lo` update.
- `hi`  out  WIDTH  product bits [2W-1:W].
- `lo`  out  WIDTH  product bits [W-1:0].

## Operation
- States: IDLE, RUN, FINISH.
- IDLE with `start`=1: accept the request.
  - Extend `a` and `b` to W+1 bits: sign-extend if `signed_mode`=1, zero-extend otherwise.
  - M ← ext(a).
  - P (2W+3 bits) ← {W+1 zeros, ext(b), 1'b0}.
  - Counter ← 0; state → RUN.
- RUN step, one per cycle, inspecting P[1:0]:
  - 01: upper field P[2W+2:W+2] += M.
  - 10: upper field −= M.
  - 00 or 11: no add.
  - Then arithmetic-shift the whole P right by 1, replicating the post-add MSB.
  - Counter increments each step. After W+1 steps, state → FINISH.
- The upper field is W+1 bits with modulo arithmetic. −M is always representable, so no overflow handling is required.
- FINISH: `lo` ← P[W:1], `hi` ← P[2W:W+1], `done` ← 1, state → IDLE.
- `hi`/`lo` hold their value until the next FINISH. They are never cleared at accept.
- `start` is ignored in RUN and FINISH, with no queuing. Changes to `a`, `b` or `signed_mode` after accept have no effect.
- Reset, including in the middle of an operation:
  - State → IDLE.
  - `hi`, `lo`, P, M and counter → 0.
  - `busy`, `done` → 0.
  - The in-flight result is discarded, and no `done` is produced for it.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0.
- Start accepted at edge k:
  - `busy` = 1 from after edge k.
  - RUN steps occur at edges k+1 … k+W+1.
  - FINISH at edge k+W+2: `hi`/`lo` valid and `done`=1 during the cycle after edge k+W+2.
  - `busy`=0 from the same edge.
- Latency: W+2 cycles from accept to result (34 for W=32). Throughput: one product per W+2 cycles.
- Back-to-back: `start` held high during the `done` cycle is accepted at that edge, because the state is IDLE.
- `reset` has priority over `start` in the same cycle.
- Counter width: $clog2(WIDTH+2).

## Structure
- Shared package `mult_pkg`:
  - state enum `mult_state_t` (IDLE, RUN, FINISH);
  - Booth op encoding constants (BOOTH_NOP, BOOTH_ADD, BOOTH_SUB);
  - mode constants MODE_UNSIGNED=0, MODE_SIGNED=1.
- One sub-module `booth_step #(WIDTH)`: purely combinational. It takes P and M and produces the next P (decode P[1:0], add/sub on the upper field, arithmetic shift). The top module holds the FSM, counter, and the P, M, `hi` and `lo` registers.

## Test plan
- W=32, signed, a=0xFFFFFFFF, b=0xFFFFFFFF → after 34 cycles `hi`=0x00000000, `lo`=0x00000001, `done` high exactly 1 cycle.
- W=32, unsigned, a=b=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001. Same operands signed, a=0x80000000, b=0x80000000 → `hi`=0x40000000, `lo`=0x00000000.
- W=32, signed, a=−3 (0xFFFFFFFD), b=5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. Then back-to-back start during `done` with unsigned a=7, b=6 → `hi`=0, `lo`=42 exactly 34 cycles later.
- W=8, unsigned, a=0xFF, b=0x02 → `hi`=0x01, `lo`=0xFE, latency 10. Same operands signed → `hi`=0xFF, `lo`=0xFE.
- Start pulsed again mid-RUN with different operands → ignored; the first result is delivered and only one `done` pulse occurs.
- Reset asserted at step 10 of a running op → next cycle `busy`=0, `hi`=`lo`=0, no `done`. A new start then completes normally.
